// File: rtl/writeback_queue_if.sv
// Producer/bank-side bundle of the writeback queue: load and ALU result
// handshakes plus the registered register-bank write port.
interface writeback_queue_if #(
    parameter int unsigned Index_size = 4,
    parameter int unsigned width      = 32
);
    logic                  mem_valid;
    logic [Index_size-1:0] mem_rd;
    logic [width-1:0]      mem_data;
    logic                  mem_ready;
    logic                  alu_valid;
    logic [Index_size-1:0] alu_rd;
    logic [width-1:0]      alu_data;
    logic                  alu_ready;
    logic                  WE;
    logic [Index_size-1:0] Rd;
    logic [width-1:0]      WD;

    modport slave (
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        output WE, Rd, WD
    );

    modport master (
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        input  WE, Rd, WD
    );
endinterface

// File: rtl/writeback_queue.sv
// In-order write queue in front of the register bank: accepts up to two
// results per cycle, retires one per cycle, and flags in-flight destinations.
module writeback_queue #(
    parameter int unsigned Index_size = 4,
    parameter int unsigned width      = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    writeback_queue_if.slave        wb,
    input  logic [Index_size-1:0]   Ra,
    input  logic [Index_size-1:0]   Rb,
    output logic                    pend_a,
    output logic                    pend_b,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [Index_size-1:0] rd;
        logic [width-1:0]      data;
    } entry_t;

    entry_t                entries_q [DEPTH];
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d, alu_slot_c;
    logic [CW-1:0]         count_q, count_d, free_c;
    logic                  we_q, we_d;
    logic [Index_size-1:0] rd_q, rd_d;
    logic [width-1:0]      wd_q, wd_d;
    logic                  mem_ready_c, alu_ready_c, mem_push_c, alu_push_c, pop_c;
    logic [1:0]            pushes_c;
    logic [PW-1:0]         off_c [DEPTH];
    logic                  hit_a_c, hit_b_c;

    // Credit comes only from the registered count; a same-cycle pop does not free a slot.
    always_comb begin
        free_c      = CW'(DEPTH) - count_q;
        mem_ready_c = (free_c >= CW'(1));
        alu_ready_c = (free_c >= CW'(2)) || ((free_c >= CW'(1)) && !wb.mem_valid);
        mem_push_c  = wb.mem_valid && mem_ready_c && (wb.mem_rd != '0);
        alu_push_c  = wb.alu_valid && alu_ready_c && (wb.alu_rd != '0);
        pop_c       = (count_q != '0);
        pushes_c    = 2'(mem_push_c) + 2'(alu_push_c);
        alu_slot_c  = tail_q + PW'(mem_push_c);
        tail_d      = tail_q + PW'(pushes_c);
        head_d      = head_q + PW'(pop_c);
        count_d     = count_q + CW'(pushes_c) - CW'(pop_c);
    end

    // Bank write port: retire the head entry, otherwise drop WE and hold Rd/WD.
    always_comb begin
        we_d = pop_c;
        rd_d = rd_q;
        wd_d = wd_q;
        if (pop_c) begin
            rd_d = entries_q[head_q].rd;
            wd_d = entries_q[head_q].data;
        end
    end

    // Load entry takes the tail slot first so it retires ahead of the ALU entry.
    always_ff @(posedge clk) begin
        if (mem_push_c) entries_q[tail_q]     <= '{rd: wb.mem_rd, data: wb.mem_data};
        if (alu_push_c) entries_q[alu_slot_c] <= '{rd: wb.alu_rd, data: wb.alu_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wd_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wd_q    <= wd_d;
        end
    end

    // Slot i holds a live entry when its distance from head is below count.
    always_comb begin
        hit_a_c = 1'b0;
        hit_b_c = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off_c[i] = PW'(i) - head_q;
            if ({1'b0, off_c[i]} < count_q) begin
                if (entries_q[PW'(i)].rd == Ra) hit_a_c = 1'b1;
                if (entries_q[PW'(i)].rd == Rb) hit_b_c = 1'b1;
            end
        end
    end

    assign pend_a = (Ra != '0) && (hit_a_c || (we_q && (rd_q == Ra)));
    assign pend_b = (Rb != '0) && (hit_b_c || (we_q && (rd_q == Rb)));

    assign wb.mem_ready = mem_ready_c;
    assign wb.alu_ready = alu_ready_c;
    assign wb.WE        = we_q;
    assign wb.Rd        = rd_q;
    assign wb.WD        = wd_q;
    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: vector table for single-cycle behaviour,
// plus streaming backpressure and mid-operation reset sequences.
module tb_writeback_queue;
    localparam int unsigned IW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] ra, rb;
    logic          pend_a, pend_b, full, empty;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_queue_if #(.Index_size(IW), .width(DW)) bus ();

    writeback_queue #(.Index_size(IW), .width(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wb(bus),
        .Ra(ra), .Rb(rb), .pend_a(pend_a), .pend_b(pend_b),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic          mv;  logic [IW-1:0] mrd; logic [DW-1:0] md;
        logic          av;  logic [IW-1:0] ard; logic [DW-1:0] ad;
        logic [IW-1:0] ra;  logic [IW-1:0] rb;
        logic          e_mr; logic e_ar; logic e_we;
        logic [IW-1:0] e_rd; logic [DW-1:0] e_wd; logic [CW-1:0] e_cnt;
        logic          e_pa; logic e_pb;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [IW-1:0] mrd, input logic [DW-1:0] md,
                         input logic av, input logic [IW-1:0] ard, input logic [DW-1:0] ad);
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    endtask

    // Stream-test model state
    logic [IW+DW-1:0] model_q [$];
    logic             exp_we;
    logic [IW-1:0]    exp_rd;
    logic [DW-1:0]    exp_wd;
    int               mi, ai, emitted, cnt;
    logic             mv, av, exp_mr, exp_ar;
    logic [IW-1:0]    mrd, ard;

    initial begin
        vecs[0]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd0,4'd0, 1'b1,1'b1,1'b0,4'd0,32'h0,        3'd0,1'b0,1'b0};
        vecs[1]  = '{1'b0,4'd0,32'h0, 1'b1,4'd5,32'hDEADBEEF,   4'd5,4'd3, 1'b1,1'b1,1'b0,4'd0,32'h0,        3'd0,1'b0,1'b0};
        vecs[2]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd5,4'd0, 1'b1,1'b1,1'b0,4'd0,32'h0,        3'd1,1'b1,1'b0};
        vecs[3]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd5,4'd0, 1'b1,1'b1,1'b1,4'd5,32'hDEADBEEF, 3'd0,1'b1,1'b0};
        vecs[4]  = '{1'b1,4'd3,32'h11, 1'b1,4'd3,32'h22,        4'd5,4'd3, 1'b1,1'b1,1'b0,4'd5,32'hDEADBEEF, 3'd0,1'b0,1'b0};
        vecs[5]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd3,4'd5, 1'b1,1'b1,1'b0,4'd5,32'hDEADBEEF, 3'd2,1'b1,1'b0};
        vecs[6]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd3,4'd3, 1'b1,1'b1,1'b1,4'd3,32'h11,       3'd1,1'b1,1'b1};
        vecs[7]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd3,4'd5, 1'b1,1'b1,1'b1,4'd3,32'h22,       3'd0,1'b1,1'b0};
        vecs[8]  = '{1'b0,4'd0,32'h0, 1'b1,4'd0,32'hFFFF,       4'd0,4'd3, 1'b1,1'b1,1'b0,4'd3,32'h22,       3'd0,1'b0,1'b0};
        vecs[9]  = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd0,4'd3, 1'b1,1'b1,1'b0,4'd3,32'h22,       3'd0,1'b0,1'b0};
        vecs[10] = '{1'b1,4'd0,32'h5, 1'b1,4'd0,32'h6,          4'd0,4'd0, 1'b1,1'b1,1'b0,4'd3,32'h22,       3'd0,1'b0,1'b0};
        vecs[11] = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd3,4'd0, 1'b1,1'b1,1'b0,4'd3,32'h22,       3'd0,1'b0,1'b0};
        vecs[12] = '{1'b0,4'd0,32'h0, 1'b0,4'd0,32'h0,          4'd0,4'd0, 1'b1,1'b1,1'b0,4'd3,32'h22,       3'd0,1'b0,1'b0};

        // Reset state
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        ra = '0; rb = '0;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.WE), 32'd0);
        chk("rst_rd", 32'(bus.Rd), 32'd0);
        chk("rst_wd", bus.WD, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            chk($sformatf("idle%0d_we", c), 32'(bus.WE), 32'd0);
            chk($sformatf("idle%0d_rd", c), 32'(bus.Rd), 32'd0);
            chk($sformatf("idle%0d_wd", c), bus.WD, 32'd0);
            chk($sformatf("idle%0d_empty", c), 32'(empty), 32'd1);
        end

        // Table: inputs applied for one cycle, outputs observed before its closing edge
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].mv, vecs[i].mrd, vecs[i].md, vecs[i].av, vecs[i].ard, vecs[i].ad);
            ra = vecs[i].ra; rb = vecs[i].rb;
            #1;
            chk($sformatf("v%0d_mem_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_mr));
            chk($sformatf("v%0d_alu_ready", i), 32'(bus.alu_ready), 32'(vecs[i].e_ar));
            chk($sformatf("v%0d_we", i), 32'(bus.WE), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_rd", i), 32'(bus.Rd), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_wd", i), bus.WD, vecs[i].e_wd);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_pend_a", i), 32'(pend_a), 32'(vecs[i].e_pa));
            chk($sformatf("v%0d_pend_b", i), 32'(pend_b), 32'(vecs[i].e_pb));
        end

        // Streaming: mem offers odd rd 1..11, ALU even rd 2..12, both held valid
        exp_we = 1'b0; exp_rd = 4'd3; exp_wd = 32'h22;
        mi = 0; ai = 0; emitted = 0;
        ra = '0; rb = '0;
        for (int c = 0; c < 40 && emitted < 12; c++) begin
            @(negedge clk);
            mv  = (mi < 6);
            av  = (ai < 6);
            mrd = IW'(2 * mi + 1);
            ard = IW'(2 * ai + 2);
            drive(mv, mrd, 32'hA000_0000 | 32'(mrd), av, ard, 32'hB000_0000 | 32'(ard));
            #1;
            cnt    = model_q.size();
            exp_mr = (cnt < 4);
            exp_ar = (cnt <= 2) || ((cnt < 4) && !mv);
            chk($sformatf("s%0d_mem_ready", c), 32'(bus.mem_ready), 32'(exp_mr));
            chk($sformatf("s%0d_alu_ready", c), 32'(bus.alu_ready), 32'(exp_ar));
            chk($sformatf("s%0d_count", c), 32'(count), 32'(cnt));
            chk($sformatf("s%0d_full", c), 32'(full), 32'(cnt == 4));
            chk($sformatf("s%0d_we", c), 32'(bus.WE), 32'(exp_we));
            chk($sformatf("s%0d_rd", c), 32'(bus.Rd), 32'(exp_rd));
            chk($sformatf("s%0d_wd", c), bus.WD, exp_wd);
            if (model_q.size() > 0) begin
                {exp_rd, exp_wd} = model_q.pop_front();
                exp_we = 1'b1;
                emitted++;
            end else begin
                exp_we = 1'b0;
            end
            if (mv && exp_mr) begin
                model_q.push_back({mrd, 32'hA000_0000 | 32'(mrd)});
                mi++;
            end
            if (av && exp_ar) begin
                model_q.push_back({ard, 32'hB000_0000 | 32'(ard)});
                ai++;
            end
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("s_last_we", 32'(bus.WE), 32'(exp_we));
        chk("s_last_rd", 32'(bus.Rd), 32'(exp_rd));
        chk("s_last_wd", bus.WD, exp_wd);
        chk("s_last_count", 32'(count), 32'd0);
        chk("s_emitted", 32'(emitted), 32'd12);
        chk("s_mem_accepted", 32'(mi), 32'd6);
        chk("s_alu_accepted", 32'(ai), 32'd6);

        // Reset mid-operation with three entries queued
        @(negedge clk);
        drive(1'b1, 4'd1, 32'h101, 1'b1, 4'd2, 32'h102);
        @(negedge clk);
        drive(1'b1, 4'd3, 32'h103, 1'b1, 4'd4, 32'h104);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        chk("mr_pre_count", 32'(count), 32'd3);
        chk("mr_pre_we", 32'(bus.WE), 32'd1);
        chk("mr_pre_rd", 32'(bus.Rd), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_we", 32'(bus.WE), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_rd", 32'(bus.Rd), 32'd0);
        chk("mr_wd", bus.WD, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            chk($sformatf("mr_post%0d_we", c), 32'(bus.WE), 32'd0);
            chk($sformatf("mr_post%0d_count", c), 32'(count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
